display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with blanking gaps between digits,
// tear-free double-buffered value loading, and optional leading-zero suppression.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        load_ack,
  output logic        frame_done
);
  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   disp, pend, disp_nx;
  logic          pend_v, commit, suppress, lit;
  logic [3:0]    nib_nx;

  always_comb begin
    nxt    = state;
    idx_nx = idx;
    commit = 1'b0;
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          nxt    = S_BLANK;
          idx_nx = 2'd0;
          commit = 1'b1;
        end
        S_BLANK: if (cnt == '0) nxt = S_DRIVE;
        S_DRIVE: if (cnt == '0) begin
          nxt    = S_BLANK;
          idx_nx = idx + 2'd1;
          commit = (idx == 2'd3);
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Frame boundaries are the only commit points, so a frame never mixes two values.
  assign disp_nx = (commit && pend_v) ? pend : disp;
  assign nib_nx  = disp_nx[idx_nx*4 +: 4];

  always_comb begin
    case (idx)
      2'd3:    suppress = blank_lz && (disp[15:12] == 4'h0);
      2'd2:    suppress = blank_lz && (disp[15:8]  == 8'h0);
      2'd1:    suppress = blank_lz && (disp[15:4]  == 12'h0);
      default: suppress = 1'b0;
    endcase
  end

  // idx is unchanged when entering or staying in DRIVE, so suppress refers to this digit.
  assign lit = (nxt == S_DRIVE) && !suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_v     <= 1'b0;
      bcd        <= 4'h0;
      seg        <= 7'h00;
      an         <= 4'b1111;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      idx   <= idx_nx;
      disp  <= disp_nx;
      if (nxt != state) begin
        case (nxt)
          S_BLANK: cnt <= BLANK_LD;
          S_DRIVE: cnt <= DRIVE_LD;
          default: cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (nxt == S_BLANK && state != S_BLANK) bcd <= nib_nx;
      an         <= lit ? ~(4'b0001 << idx) : 4'b1111;
      seg        <= lit ? seg_in : 7'h00;
      load_ack   <= load;
      frame_done <= commit && (state == S_DRIVE);
      // A load in the commit cycle wins: the old pend is committed, the new one stays pending.
      if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
    end
  end
endmodule
